// File: rtl/dm_ram_port.sv
// Byte-lane data RAM port: multi-cycle access that stalls the memory stage until done.
// Optional `DM_WRITE_POST_EN lets stores retire in the accept cycle while the RAM write finishes in the background.
module dm_ram_port #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [3:0]  wea_mem,
    input  logic [31:0] Data_write_to_dm,
    output logic [31:0] Data_read_from_dm,
    output logic        mem_stall,
    output logic        dm_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                r_state, w_state_next;
    logic [3:0]            r_cnt, w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [3:0]            r_wea;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic                  r_oor;
    logic                  r_posted;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [0:DEPTH-1];

    logic                  w_post;
    logic                  w_accept;
    logic                  w_fire;
    logic [3:0]            w_lane_we;
    logic                  w_unused;

    // Byte offset bits never affect the word access; lanes come pre-positioned.
    assign w_unused = &{1'b0, Addr_in[1:0]};

`ifdef DM_WRITE_POST_EN
    assign w_post = mem_w;
`else
    assign w_post = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && mem_req;
    assign w_fire   = (r_state == ACCESS) && (r_cnt == 4'd1);

    // A posted store is released in its accept cycle; everything else holds until DONE.
    assign mem_stall = mem_req & ~rst & (r_state != DONE)
                     & ~((r_state == IDLE) & w_post);

    assign Data_read_from_dm = r_rdata;
    assign dm_err            = r_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_state_next = ACCESS;
                    w_cnt_next   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = r_posted ? IDLE : DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_fire & r_oor;
            if (w_fire && !r_we) begin
                r_rdata <= r_oor ? 32'd0 : r_mem[r_word];
            end
        end
    end

    // Request payload is only consumed while in ACCESS, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_word   <= Addr_in[ADDR_WIDTH+1:2];
            r_oor    <= (Addr_in[31:ADDR_WIDTH+2] != '0);
            r_wea    <= wea_mem;
            r_wdata  <= Data_write_to_dm;
            r_we     <= mem_w;
            r_posted <= w_post;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
        assign w_lane_we[gi] = w_fire & ~rst & r_we & ~r_oor & r_wea[gi];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_lane_we[i]) begin
                r_mem[r_word][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/dm_ram_port.md
# dm_ram_port

Byte-lane data RAM port with configurable access latency, sitting directly downstream of the data-memory byte-lane controller. Consumes that controller's word-aligned write data and 4-bit lane enables, performs the access over a fixed number of wait cycles, and returns the raw 32-bit word the controller aligns and extends for loads. Drives a stall signal that holds the pipeline's memory stage until the access completes.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2^ADDR_WIDTH words of 32 bits
- WAIT_CYCLES, 2, RAM access cycles per access; legal range 1..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_req  in  1  memory-stage instruction is a load or store; held stable by pipeline while mem_stall=1
- mem_w  in  1  1 = store, 0 = load
- Addr_in  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word
- wea_mem  in  4  byte-lane write enables, bit i = bits [8i+7:8i]
- Data_write_to_dm  in  32  lane-positioned store data
- Data_read_from_dm  out  32  registered raw read word
- mem_stall  out  1  combinational; pipeline must hold while 1
- dm_err  out  1  one-cycle pulse: completed access had out-of-range address

## Operation
- States: IDLE, ACCESS, DONE. Counter cnt, 4 bits. Latched: word index, wea, wdata, mem_w, range flag.
- IDLE, mem_req=1: latch request; range flag = (Addr_in[31:ADDR_WIDTH+2] != 0); cnt <= WAIT_CYCLES; -> ACCESS. mem_req=0: stay.
- ACCESS: cnt decrements each cycle; at the edge where cnt==1: perform access, -> DONE.
- Access write: for each i with latched wea[i]=1, RAM[word][8i+7:8i] <= wdata lane i; other lanes unchanged. wea=0000 with mem_w=1 writes nothing.
- Access read (mem_w=0): Data_read_from_dm <= RAM[word].
- Out of range: no RAM write; reads load 0; dm_err=1 during DONE.
- DONE: stall released; -> IDLE next edge regardless of mem_req. A new mem_req in the following IDLE cycle starts a new access (back-to-back requests take WAIT_CYCLES+2 cycles each).
- mem_stall = mem_req & ~rst & (state != DONE), subject to Configuration.
- Data_read_from_dm holds its value until the next completed read; writes never change it.
- Lane enables and alignment are not checked; the upstream controller guarantees them.

## Timing
- Reset: state=IDLE, cnt=0, Data_read_from_dm=0, dm_err=0, mem_stall=0 while rst=1. RAM contents not cleared.
- Reset mid-access: access aborted, no write performed, IDLE on next cycle.
- Blocking access: request seen in IDLE cycle T; mem_stall=1 for cycles T..T+WAIT_CYCLES; DONE at T+WAIT_CYCLES+1 with mem_stall=0, read data valid and dm_err valid that cycle.
- WAIT_CYCLES=1: IDLE, ACCESS, DONE; 2 stall cycles.
- mem_req dropping while stalled is illegal; behaviour then: access still completes.

## Configuration
- DM_WRITE_POST_EN defined: stores are posted. Store in IDLE: latched, -> ACCESS with posted flag set, mem_stall=0 in the accept cycle so the pipeline proceeds. A posted access goes ACCESS -> IDLE directly (no DONE, no stall release needed), dm_err pulses for one cycle on that edge if out of range. Any mem_req while a posted access is in ACCESS sees mem_stall=1 and is accepted in the following IDLE. Loads unchanged.
- Undefined: stores and loads both use the blocking sequence.

## Test plan
- WAIT_CYCLES=2, store word 0x1122_3344 to addr 0x10, wea=1111 -> mem_stall high 3 cycles, low in DONE; then load addr 0x10 -> Data_read_from_dm=0x1122_3344 in DONE.
- Byte store 0xAA00_0000, wea=1000 to addr 0x13 over 0x1122_3344 -> subsequent load of addr 0x10 reads 0xAA22_3344.
- Load addr 0x0000_1000 with ADDR_WIDTH=10 -> Data_read_from_dm=0, dm_err=1 for exactly the DONE cycle, RAM unchanged.
- rst asserted during ACCESS of a word store to 0x20 -> IDLE next cycle, mem_stall=0, later load of 0x20 returns prior contents.
- DM_WRITE_POST_EN: store then immediate load of same word -> store accept cycle mem_stall=0; load stalls until posted write finishes, then WAIT_CYCLES+1 more cycles; returns stored value.
